// File: rtl/led_pkg.sv
// Shared sizes and types for the 144-LED frame scheduler and its write arbiter.
package led_pkg;

   localparam int unsigned NUM_LEDS     = 144;
   localparam int unsigned BITS_PER_LED = 24;
   localparam int unsigned FRAME_BITS   = NUM_LEDS * BITS_PER_LED;

   typedef enum logic [2:0] {
      StShift,
      StLatch,
      StSwap,
      StRelease,
      StWaitLow
   } sched_state_e;

   typedef struct packed {
      logic [7:0] g;
      logic [7:0] r;
      logic [7:0] b;
   } pixel_t;

endpackage

// File: rtl/led_write_arb.sv
// Two-way round-robin arbiter for shadow-buffer pixel writes, with a stall that blocks both.
module led_write_arb
   import led_pkg::*;
#(
   parameter int unsigned IDX_W = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    stall,
   input  logic                    a_valid,
   input  logic [IDX_W-1:0]        a_idx,
   input  logic [BITS_PER_LED-1:0] a_rgb,
   input  logic                    b_valid,
   input  logic [IDX_W-1:0]        b_idx,
   input  logic [BITS_PER_LED-1:0] b_rgb,
   output logic                    gnt_a,
   output logic                    gnt_b,
   output logic [IDX_W-1:0]        w_idx,
   output pixel_t                  w_pix
);

   // prio_b_q set means B wins the next contested cycle.
   logic prio_b_q, prio_b_d;

   always_comb begin
      gnt_a    = a_valid & ~stall & (~b_valid | ~prio_b_q);
      gnt_b    = b_valid & ~stall & (~a_valid | prio_b_q);
      w_idx    = gnt_b ? b_idx : a_idx;
      w_pix    = gnt_b ? pixel_t'(b_rgb) : pixel_t'(a_rgb);
      prio_b_d = prio_b_q;
      if (a_valid && b_valid && !stall) begin
         prio_b_d = gnt_a;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prio_b_q <= 1'b0;
      end else begin
         prio_b_q <= prio_b_d;
      end
   end

endmodule

// File: rtl/led_frame_scheduler.sv
// Double-buffered LED frame store: shadow writes, commit-on-frame-boundary swap, and
// WS2812 latch-gap timing that hands reset_done back to the string shifter.
module led_frame_scheduler
   import led_pkg::*;
#(
   parameter int unsigned RESET_CYCLES = 14400,
   parameter int unsigned IDX_W        = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    a_valid,
   input  logic [IDX_W-1:0]        a_idx,
   input  logic [BITS_PER_LED-1:0] a_rgb,
   output logic                    a_ready,
   input  logic                    b_valid,
   input  logic [IDX_W-1:0]        b_idx,
   input  logic [BITS_PER_LED-1:0] b_rgb,
   output logic                    b_ready,
   input  logic                    commit,
   input  logic                    update_bits,
   output logic                    reset_done,
   output logic [FRAME_BITS-1:0]   rgb_string,
   output logic                    commit_pending,
   output logic [15:0]             frame_count,
   output logic                    idx_err
);

   localparam int unsigned CntW = $clog2(RESET_CYCLES);

   sched_state_e          state_q, state_d;
   logic [CntW-1:0]       cnt_q, cnt_d;
   pixel_t                shadow_q [NUM_LEDS];
   pixel_t                shadow_d [NUM_LEDS];
   logic [FRAME_BITS-1:0] active_q, active_d;
   logic                  pending_q, pending_d;
   logic [15:0]           fc_q, fc_d;
   logic                  idx_err_q, idx_err_d;
   logic                  reset_done_q, reset_done_d;

   logic                  gnt_a, gnt_b;
   logic [IDX_W-1:0]      w_idx;
   pixel_t                w_pix;

   led_write_arb #(
      .IDX_W(IDX_W)
   ) u_arb (
      .clk    (clk),
      .rst    (rst),
      .stall  (state_q == StSwap),
      .a_valid(a_valid),
      .a_idx  (a_idx),
      .a_rgb  (a_rgb),
      .b_valid(b_valid),
      .b_idx  (b_idx),
      .b_rgb  (b_rgb),
      .gnt_a  (gnt_a),
      .gnt_b  (gnt_b),
      .w_idx  (w_idx),
      .w_pix  (w_pix)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      shadow_d     = shadow_q;
      active_d     = active_q;
      pending_d    = pending_q;
      fc_d         = fc_q;
      idx_err_d    = idx_err_q;
      reset_done_d = 1'b0;

      if (gnt_a || gnt_b) begin
         if (32'(w_idx) < NUM_LEDS) begin
            shadow_d[w_idx] = w_pix;
         end else begin
            idx_err_d = 1'b1;
         end
      end
      if (commit) begin
         pending_d = 1'b1;
      end

      unique case (state_q)
         StShift: begin
            if (update_bits) begin
               state_d = StLatch;
               cnt_d   = '0;
            end
         end
         StLatch: begin
            if (cnt_q == CntW'(RESET_CYCLES - 1)) begin
               state_d = StSwap;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StSwap: begin
            // A commit arriving in this very cycle survives for the next frame.
            if (pending_q) begin
               for (int unsigned i = 0; i < NUM_LEDS; i++) begin
                  active_d[FRAME_BITS-1-BITS_PER_LED*i -: BITS_PER_LED] = shadow_q[i];
               end
               pending_d = commit;
               fc_d      = fc_q + 16'd1;
            end
            state_d      = StRelease;
            reset_done_d = 1'b1;
         end
         StRelease: state_d = StWaitLow;
         StWaitLow: begin
            if (!update_bits) begin
               state_d = StShift;
            end
         end
         default: state_d = StShift;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= StShift;
         cnt_q        <= '0;
         shadow_q     <= '{default: '0};
         active_q     <= '0;
         pending_q    <= 1'b0;
         fc_q         <= '0;
         idx_err_q    <= 1'b0;
         reset_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         shadow_q     <= shadow_d;
         active_q     <= active_d;
         pending_q    <= pending_d;
         fc_q         <= fc_d;
         idx_err_q    <= idx_err_d;
         reset_done_q <= reset_done_d;
      end
   end

   assign a_ready        = gnt_a;
   assign b_ready        = gnt_b;
   assign reset_done     = reset_done_q;
   assign rgb_string     = active_q;
   assign commit_pending = pending_q;
   assign frame_count    = fc_q;
   assign idx_err        = idx_err_q;

endmodule

// File: tb/tb_led_frame_scheduler.sv
// Scoreboard bench for led_frame_scheduler with a short latch gap.
module tb_led_frame_scheduler;

   localparam int R  = 8;
   localparam int FB = 3456;

   logic          clk = 1'b0;
   logic          rst;
   logic          a_valid, b_valid, a_ready, b_ready;
   logic [7:0]    a_idx, b_idx;
   logic [23:0]   a_rgb, b_rgb;
   logic          commit, update_bits, reset_done, commit_pending, idx_err;
   logic [FB-1:0] rgb_string;
   logic [15:0]   frame_count;

   typedef struct packed {
      logic [FB-1:0] frame;
      logic [15:0]   fc;
      logic          pending;
   } exp_t;

   exp_t          exp_q[$];
   logic [1:0]    gnt_q[$];
   logic [23:0]   m_shadow [144];
   logic [FB-1:0] m_active;
   logic          m_pending;
   logic [15:0]   m_fc;
   int            errors = 0;
   int            checks = 0;

   always #5 clk = ~clk;

   led_frame_scheduler #(
      .RESET_CYCLES(R),
      .IDX_W       (8)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .a_valid       (a_valid),
      .a_idx         (a_idx),
      .a_rgb         (a_rgb),
      .a_ready       (a_ready),
      .b_valid       (b_valid),
      .b_idx         (b_idx),
      .b_rgb         (b_rgb),
      .b_ready       (b_ready),
      .commit        (commit),
      .update_bits   (update_bits),
      .reset_done    (reset_done),
      .rgb_string    (rgb_string),
      .commit_pending(commit_pending),
      .frame_count   (frame_count),
      .idx_err       (idx_err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 144; i++) m_shadow[i] = '0;
      m_active  = '0;
      m_pending = 1'b0;
      m_fc      = '0;
      exp_q.delete();
   endtask

   function automatic logic [FB-1:0] build_frame();
      logic [FB-1:0] f;
      f = '0;
      for (int i = 0; i < 144; i++) f[FB-1-24*i -: 24] = m_shadow[i];
      return f;
   endfunction

   task automatic do_write(input bit use_b, input logic [7:0] idx, input logic [23:0] rgb);
      int n;
      n = 0;
      if (use_b) begin b_valid = 1'b1; b_idx = idx; b_rgb = rgb; end
      else       begin a_valid = 1'b1; a_idx = idx; a_rgb = rgb; end
      @(negedge clk);
      while (!(use_b ? b_ready : a_ready) && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 20) begin
         errors++;
         $display("FAIL write_ready: ready stayed 0 for 20 cycles, required 1");
      end
      tick();
      a_valid = 1'b0;
      b_valid = 1'b0;
      if (idx < 144) m_shadow[idx] = rgb;
   endtask

   task automatic do_commit();
      commit = 1'b1;
      tick();
      commit = 1'b0;
      m_pending = 1'b1;
   endtask

   // Pushes the expected post-frame state, plays one frame, then checks timing and contents.
   task automatic run_frame(input int hold, input int commit_at);
      exp_t e;
      int   first, pulses;
      first  = -1;
      pulses = 0;
      if (m_pending) begin
         m_active  = build_frame();
         m_fc      = m_fc + 16'd1;
         m_pending = 1'b0;
      end
      if (commit_at >= 0) m_pending = 1'b1;
      e.frame   = m_active;
      e.fc      = m_fc;
      e.pending = m_pending;
      exp_q.push_back(e);
      update_bits = 1'b1;
      for (int n = 0; n < hold + R + 8; n++) begin
         @(negedge clk);
         if (reset_done) begin
            pulses++;
            if (first < 0) first = n;
         end
         @(posedge clk);
         #1;
         if (n + 1 == hold) update_bits = 1'b0;
         commit = (n + 1 == commit_at);
      end
      commit = 1'b0;
      e = exp_q.pop_front();
      checks++;
      if (first !== R + 2) begin
         errors++;
         $display("FAIL reset_done_latency: got %0d cycles, required %0d", first, R + 2);
      end
      checks++;
      if (pulses !== 1) begin
         errors++;
         $display("FAIL reset_done_pulses: got %0d, required 1", pulses);
      end
      checks++;
      if (rgb_string !== e.frame) begin
         errors++;
         for (int i = 0; i < 144; i++) begin
            if (rgb_string[FB-1-24*i -: 24] !== e.frame[FB-1-24*i -: 24]) begin
               $display("FAIL frame_data: led %0d got %06h required %06h", i,
                        rgb_string[FB-1-24*i -: 24], e.frame[FB-1-24*i -: 24]);
               break;
            end
         end
      end
      checks++;
      if (frame_count !== e.fc) begin
         errors++;
         $display("FAIL frame_count: got %0d, required %0d", frame_count, e.fc);
      end
      checks++;
      if (commit_pending !== e.pending) begin
         errors++;
         $display("FAIL commit_pending: got %0b, required %0b", commit_pending, e.pending);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      model_reset();
      checks++;
      if (rgb_string !== '0) begin errors++; $display("FAIL reset_rgb: nonzero, required 0"); end
      checks++;
      if (frame_count !== 16'd0) begin
         errors++; $display("FAIL reset_fc: got %0d, required 0", frame_count);
      end
      checks++;
      if (commit_pending !== 1'b0) begin
         errors++; $display("FAIL reset_pending: got %0b, required 0", commit_pending);
      end
      checks++;
      if (idx_err !== 1'b0) begin errors++; $display("FAIL reset_idx_err: got %0b, required 0", idx_err); end
      checks++;
      if (reset_done !== 1'b0) begin
         errors++; $display("FAIL reset_done_idle: got %0b, required 0", reset_done);
      end
      a_valid = 1'b1;
      #1;
      checks++;
      if (a_ready !== 1'b1) begin errors++; $display("FAIL reset_a_ready: got %0b, required 1", a_ready); end
      a_valid = 1'b0;
   endtask

   task automatic test_basic_frame();
      do_write(1'b0, 8'd0, 24'hFF0000);
      do_commit();
      checks++;
      if (commit_pending !== 1'b1) begin
         errors++; $display("FAIL commit_set: got %0b, required 1", commit_pending);
      end
      run_frame(1, -1);
      checks++;
      if (rgb_string[3455:3432] !== 24'hFF0000) begin
         errors++; $display("FAIL led0: got %06h, required ff0000", rgb_string[3455:3432]);
      end
   endtask

   task automatic test_arbitration();
      logic [23:0] a_data [2];
      logic [23:0] b_data [2];
      logic [1:0]  exp;
      int          ai, bi, ea, eb;
      a_data = '{24'hA0A0A0, 24'hA1A1A1};
      b_data = '{24'hB0B0B0, 24'hB1B1B1};
      ai = 0; bi = 0; ea = 0; eb = 0;
      gnt_q.push_back(2'b10);
      gnt_q.push_back(2'b01);
      gnt_q.push_back(2'b10);
      gnt_q.push_back(2'b01);
      a_valid = 1'b1; a_idx = 8'd1; a_rgb = a_data[0];
      b_valid = 1'b1; b_idx = 8'd2; b_rgb = b_data[0];
      for (int c = 0; c < 4; c++) begin
         logic ga, gb;
         @(negedge clk);
         exp = gnt_q.pop_front();
         ga  = a_ready;
         gb  = b_ready;
         checks++;
         if ({ga, gb} !== exp) begin
            errors++;
            $display("FAIL arb_grant%0d: got a=%0b b=%0b, required a=%0b b=%0b", c, ga, gb,
                     exp[1], exp[0]);
         end
         if (exp[1] && ea < 2) begin m_shadow[1] = a_data[ea]; ea++; end
         if (exp[0] && eb < 2) begin m_shadow[2] = b_data[eb]; eb++; end
         tick();
         if (ga && a_valid) begin
            ai++;
            if (ai >= 2) a_valid = 1'b0; else a_rgb = a_data[ai];
         end
         if (gb && b_valid) begin
            bi++;
            if (bi >= 2) b_valid = 1'b0; else b_rgb = b_data[bi];
         end
      end
      a_valid = 1'b0;
      b_valid = 1'b0;
      do_commit();
      run_frame(1, -1);
   endtask

   task automatic test_commit_in_swap();
      do_write(1'b0, 8'd5, 24'h123456);
      run_frame(1, R + 1);
      run_frame(1, -1);
   endtask

   task automatic test_idx_err();
      checks++;
      if (idx_err !== 1'b0) begin errors++; $display("FAIL idx_err_pre: got %0b, required 0", idx_err); end
      do_write(1'b1, 8'd144, 24'hABCDEF);
      checks++;
      if (idx_err !== 1'b1) begin errors++; $display("FAIL idx_err_set: got %0b, required 1", idx_err); end
      do_commit();
      run_frame(1, -1);
      checks++;
      if (idx_err !== 1'b1) begin
         errors++; $display("FAIL idx_err_sticky: got %0b, required 1", idx_err);
      end
   endtask

   task automatic test_hold_update();
      run_frame(R + 23, -1);
      run_frame(1, -1);
   endtask

   task automatic test_rst_mid_latch();
      int pulses;
      pulses = 0;
      do_write(1'b0, 8'd7, 24'h00FF00);
      do_commit();
      update_bits = 1'b1;
      tick();
      update_bits = 1'b0;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      model_reset();
      checks++;
      if (rgb_string !== '0) begin errors++; $display("FAIL rst_rgb: nonzero, required 0"); end
      checks++;
      if (commit_pending !== 1'b0) begin
         errors++; $display("FAIL rst_pending: got %0b, required 0", commit_pending);
      end
      checks++;
      if (frame_count !== 16'd0) begin
         errors++; $display("FAIL rst_fc: got %0d, required 0", frame_count);
      end
      for (int n = 0; n < R + 6; n++) begin
         @(negedge clk);
         if (reset_done) pulses++;
      end
      tick();
      checks++;
      if (pulses !== 0) begin errors++; $display("FAIL rst_no_pulse: got %0d pulses, required 0", pulses); end
      run_frame(1, -1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; a_idx = '0; b_idx = '0;
      a_rgb = '0; b_rgb = '0; commit = 1'b0; update_bits = 1'b0;
      test_reset();
      test_basic_frame();
      test_arbitration();
      test_commit_in_swap();
      test_idx_err();
      test_hold_update();
      test_rst_mid_latch();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/led_frame_scheduler.md
Name: led_frame_scheduler

Overview:
Owns the pixel frame for the 144-LED strip and sequences the LED string shifter. Two write requesters (host link and pattern generator) share a shadow frame buffer through a round-robin arbiter. A commit request copies the shadow buffer into the active buffer. The active buffer drives rgb_string into the string shifter. The block also times the WS2812 latch/reset gap after each frame and returns reset_done to restart shifting.

Parameters:
NUM_LEDS, 144, LEDs on the strip
BITS_PER_LED, 24, GRB bits per LED
RESET_CYCLES, 14400, clk cycles of latch low time (300 us at 48 MHz); minimum 2
IDX_W, 8, pixel index width

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
a_valid  in  1  requester A (host) write request
a_idx  in  IDX_W  A pixel index
a_rgb  in  24  A pixel data
a_ready  out  1  A write accepted this cycle
b_valid  in  1  requester B (pattern gen) write request
b_idx  in  IDX_W  B pixel index
b_rgb  in  24  B pixel data
b_ready  out  1  B write accepted this cycle
commit  in  1  single-cycle pulse: publish shadow buffer at next frame boundary
update_bits  in  1  high while the string shifter has finished a frame
reset_done  out  1  single-cycle pulse: latch gap elapsed, shifter may restart
rgb_string  out  NUM_LEDS*BITS_PER_LED  active frame; LED i at bits [FRAME_BITS-1-24*i -: 24]
commit_pending  out  1  commit accepted, not yet swapped
frame_count  out  16  frames swapped since reset, wraps at 65535->0
idx_err  out  1  sticky: a write with idx >= NUM_LEDS was accepted

Behaviour:
- Reset: shadow and active buffers all zero, state SHIFT, reset_done=0, commit_pending=0, frame_count=0, idx_err=0, round-robin pointer favours A.
- States:
  - SHIFT: wait for update_bits=1, then go to LATCH with the latch counter cleared.
  - LATCH: count RESET_CYCLES cycles. On the last count go to SWAP.
  - SWAP: exactly 1 cycle. If commit_pending, active<=shadow, commit_pending<=0 and frame_count++. Else active is unchanged. Go to RELEASE.
  - RELEASE: reset_done=1 for exactly this cycle. Go to WAIT_LOW.
  - WAIT_LOW: stay until update_bits=0, then go to SHIFT. This prevents retriggering on the held update_bits.
- Latency: update_bits rising to reset_done high is RESET_CYCLES+2 cycles.
- rgb_string changes only on the clock edge leaving SWAP. It is stable during SHIFT.
- Writes:
  - Accepted in every state except SWAP. In SWAP both ready signals are 0, so the copied frame is consistent.
  - ready is combinational from valid, state and the arbiter.
  - A write is committed on the edge where valid&ready.
  - Shadow pixel idx is updated the following cycle.
- Arbitration:
  - Only one requester valid: it is granted.
  - Both valid: grant the one not granted last.
  - The pointer updates only on a contested grant.
  - A requester holds valid/idx/rgb stable until ready.
- idx >= NUM_LEDS: write accepted (ready=1), data dropped, idx_err set. idx_err clears only on rst.
- commit:
  - Sets commit_pending in any state.
  - A commit in the SWAP cycle itself is not consumed by that swap; it stays pending for the next frame.
  - Commit while already pending has no extra effect.
- Write and swap ordering: writes accepted before SWAP are in the copied frame. Writes after SWAP go to the next commit.
- rst mid-frame (any state): all state cleared as at reset. The shifter is expected to be reset by the same rst.

Decomposition:
- Package led_pkg holds:
  - NUM_LEDS, BITS_PER_LED, FRAME_BITS (3456).
  - The scheduler state enum {SHIFT, LATCH, SWAP, RELEASE, WAIT_LOW}.
  - The pixel struct {g, r, b} of 8 bits each.
- Sub-module led_write_arb is natural: a 2-way round-robin arbiter with a stall input. Outputs are the grants and the muxed idx/rgb.

Test Plan:
- Reset, then A writes idx 0 = 0xFF0000 and commit; drive an update_bits pulse -> after RESET_CYCLES+2 cycles reset_done pulses 1 cycle, rgb_string[3455:3432]=0xFF0000, frame_count=1, commit_pending=0.
- a_valid and b_valid held for 4 cycles (idx 1 and 2) -> grants alternate A,B,A,B. The final shadow has idx1=A data and idx2=B data, visible after commit and one frame.
- Commit pulsed exactly in the SWAP cycle -> no swap of new data that frame, commit_pending=1 after SWAP, swap happens on the following frame with frame_count+1.
- B write with idx=144 -> b_ready=1, idx_err=1, rgb_string unchanged after commit and frame.
- update_bits held high for 20 cycles past RELEASE -> only one reset_done pulse, state stays WAIT_LOW until update_bits falls.
- rst asserted mid-LATCH with commit pending -> next cycle rgb_string=0, commit_pending=0, frame_count=0, no reset_done pulse.
